mdu_iter: RTL
=============

// Module: mdu_iter
// PURPOSE
//  Iterative multiply/divide unit; parametrised successor to the combinational ALU datapath.
//  Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO, and holds the HI/LO result pair.
//  Radix-2 shift-add / restoring-divide core running one bit per clock.
//  Sits in EX beside the ALU. The pipeline stalls on busy and can abort a started op via cancel.
// PARAMETERS
//  WIDTH  32  operand width, and width of each of hi and lo (even, >=4)
// PORTS
//  clk     in   1      single clock, rising edge
//  reset   in   1      asynchronous, active-low reset
//  start   in   1      request; sampled on rising edge, accepted only when busy=0
//  op      in   3      operation code (mdu_pkg), sampled with start
//  a       in   WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO data
//  b       in   WIDTH  rt operand: multiplier / divisor
//  cancel  in   1      abort the in-flight op (branch flush / exception)
//  busy    out  1      high while an op is in flight
//  done    out  1      one-cycle pulse; hi/lo hold the new result
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE; busy, done, hi, lo all 0
//   - reset mid-op discards all work
//  Op codes:
//   - MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101
//   - 110/111 are ignored (no state change)
//  MTHI/MTLO:
//   - hi (or lo) <= a at the sampling edge
//   - busy stays 0; no done pulse
//  FSM IDLE -> RUN -> FIX -> IDLE:
//   - Accept: start=1 in IDLE with a mult/div op. Latch |a|,|b| (signed ops) or a,b (unsigned).
//     Latch the result sign flags. cnt<=0; busy<=1.
//   - RUN: one step per cycle for WIDTH cycles (cnt 0..WIDTH-1), then -> FIX.
//     - mult: shift-add into a 2*WIDTH product register
//     - div: restoring step into a remainder/quotient pair
//   - FIX: one cycle. Negate product/quotient/remainder per the sign flags. Write hi/lo.
//     done<=1, busy<=0, -> IDLE.
//  Latency: start sampled at edge E0 -> hi/lo written and done=1 after edge E0+WIDTH+1.
//   - That is 33 edges for WIDTH=32; done drops after the following edge.
//  Back-to-back: a new start is accepted at the edge where done is high (state is IDLE).
//  start while busy: ignored. The bench drives op/a/b freely during busy.
//  cancel=1 while busy:
//   - next edge -> IDLE, busy=0, no done
//   - hi/lo keep their pre-op values
//   - cancel in IDLE has no effect; cancel and start together in IDLE: cancel wins
//  Arithmetic:
//   - mult: {hi,lo} = full 2*WIDTH product, signed (two's complement) or unsigned
//   - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend
//   - divide by zero: lo = all-ones, hi = a (same for signed and unsigned); uniform latency
//   - signed overflow MIN/-1: lo = MIN, hi = 0
//   - |MIN| is held as WIDTH-bit unsigned and is handled correctly by the core
//  hi/lo change only at reset, at MTHI/MTLO, or in FIX.
// STRUCTURE
//  mdu_pkg:
//   - op code localparams MDU_MULT..MDU_MTLO
//   - FSM state encoding ST_IDLE/ST_RUN/ST_FIX
//   - counter width function clog2(WIDTH+1)
//  Sub-module mdu_divstep (combinational, WIDTH-param):
//   - one restoring step: {rem,quo} in -> trial subtract -> {rem,quo} out
//  Multiply step, sign fix and FSM stay in mdu_iter.
// TESTING  (WIDTH=32)
//  1 MULT a=0xFFFFFFFD b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; done exactly 33 edges after start
//  2 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; then MULT same operands -> hi=0 lo=1
//  3 DIV -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 7/2 -> lo=3 hi=1
//  4 DIVU 100/0 -> lo=0xFFFFFFFF hi=100; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0
//  5 start DIV, pulse a second start at edge 5 (ignored), cancel at edge 10
//    -> busy=0 after edge 11, no done, hi/lo unchanged
//  6 MTHI a=0x1234 -> hi=0x1234 next edge, busy stays 0
//    reset low mid-MULT -> busy/done/hi/lo=0 immediately

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the counter-width helper.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the
// remainder, trial-subtract the divisor and keep the result if no borrow.
module mdu_divstep
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    // Shifted partial remainder needs WIDTH+1 bits, the borrow one more.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        borrow  = diff[WIDTH+1];
        rem_out = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding HI/LO: one shift-add or restoring
// step per clock on magnitudes, with a final cycle applying the result signs.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           fsm_state
);

    localparam int CW = clog2(WIDTH + 1);

    // Handshake: start is taken at a rising edge only while busy=0 (and cancel=0);
    // busy stays high until the edge that raises done (or a cancel), and done
    // is a single-cycle pulse marking hi/lo as freshly written.
    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               div_zero;

    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        abs_a     = a_neg ? -a : a;
        abs_b     = b_neg ? -b : b;
    end

    // Multiply: low half of acc holds the remaining multiplier bits.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {add_sum, acc[WIDTH-1:1]};
    end

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_in  (acc[2*WIDTH-1:WIDTH]),
        .quo_in  (acc[WIDTH-1:0]),
        .divisor (opnd),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    // A zero divisor leaves rem=|a| and quo=all-ones; only the quotient sign is suppressed.
    always_comb begin
        prod_fix = neg_main ? -acc : acc;
        quo_fix  = div_zero ? '1 : (neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            MDU_MTHI: hi <= a;
                            MDU_MTLO: lo <= a;
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                opnd     <= op[1] ? abs_b : abs_a;
                                acc      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                                is_div   <= op[1];
                                neg_main <= a_neg ^ b_neg;
                                neg_rem  <= a_neg;
                                div_zero <= (b == '0);
                                cnt      <= '0;
                                busy     <= 1'b1;
                                state    <= ST_RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        acc <= is_div ? {div_rem, div_quo} : mul_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!cancel) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule
